// File: rtl/eq_pkg.sv
// Encodings shared by the equalizer adaptation blocks: phase codes, update
// modes and the tap-update scheduler state.
package eq_pkg;

    localparam logic [2:0] PH_STARTUP = 3'd0;
    localparam logic [2:0] PH_CMA     = 3'd1;
    localparam logic [2:0] PH_LMS     = 3'd2;

    localparam logic MODE_CMA = 1'b0;
    localparam logic MODE_LMS = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } sched_state_e;

endpackage

// File: rtl/mu_gear_shifter.sv
// Step-size gear shifter: picks the per-mode initial mu, right-shifts it by the
// current gear, and advances the gear once every gear_period sweep starts.
module mu_gear_shifter
    import eq_pkg::*;
#(
    parameter int MU_W   = 16,
    parameter int GEAR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [MU_W-1:0]   mu_cma_init,
    input  logic [MU_W-1:0]   mu_lms_init,
    input  logic [31:0]       gear_period,
    input  logic [GEAR_W-1:0] gear_max,
    output logic [MU_W-1:0]   mu
);

    logic [31:0]       cnt_q, cnt_d, cnt_base, cnt_inc;
    logic [GEAR_W-1:0] shift_q, shift_d, shift_base;
    logic              last_mode_q, last_mode_d;
    logic              mode_change;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            shift_q     <= '0;
            last_mode_q <= MODE_CMA;
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            last_mode_q <= last_mode_d;
        end
    end

    // A mode switch restarts the gear schedule before mu is computed.
    always_comb begin
        mode_change = (mode != last_mode_q);
        shift_base  = mode_change ? '0 : shift_q;
        cnt_base    = mode_change ? '0 : cnt_q;
        cnt_inc     = cnt_base + 32'd1;
        mu          = ((mode == MODE_LMS) ? mu_lms_init : mu_cma_init) >> shift_base;

        cnt_d       = cnt_q;
        shift_d     = shift_q;
        last_mode_d = last_mode_q;
        if (start) begin
            last_mode_d = mode;
            cnt_d       = cnt_inc;
            shift_d     = shift_base;
            if ((gear_period != 32'd0) && (cnt_inc == gear_period)) begin
                cnt_d = '0;
                if (shift_base < gear_max) begin
                    shift_d = shift_base + GEAR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tap_update_scheduler.sv
// Sweeps tap indices 0..NTAPS-1 to the shared tap-update engine once per
// accepted error strobe, tagging each sweep with mode and gear-shifted mu.
module tap_update_scheduler
    import eq_pkg::*;
#(
    parameter int NTAPS  = 31,
    parameter int TAP_W  = 5,
    parameter int MU_W   = 16,
    parameter int GEAR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sym_valid,
    input  logic [2:0]        adaptation_phase,
    input  logic [MU_W-1:0]   mu_cma_init,
    input  logic [MU_W-1:0]   mu_lms_init,
    input  logic [31:0]       gear_period,
    input  logic [GEAR_W-1:0] gear_max,
    output logic              upd_valid,
    input  logic              upd_ready,
    output logic [TAP_W-1:0]  upd_tap,
    output logic              upd_mode,
    output logic [MU_W-1:0]   upd_mu,
    output logic              busy,
    output logic              sweep_done,
    output logic              overrun,
    output logic [15:0]       drop_count
);

    sched_state_e      state_q, state_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic              valid_q, valid_d;
    logic              mode_q, mode_d;
    logic [MU_W-1:0]   mu_q, mu_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic [15:0]       drop_q, drop_d;

    logic              phase_ok, mode_new, start, handshake, tap_last, drop;
    logic [MU_W-1:0]   mu_gear;

    mu_gear_shifter #(
        .MU_W   (MU_W),
        .GEAR_W (GEAR_W)
    ) u_gear (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode_new),
        .mu_cma_init (mu_cma_init),
        .mu_lms_init (mu_lms_init),
        .gear_period (gear_period),
        .gear_max    (gear_max),
        .mu          (mu_gear)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tap_q   <= '0;
            valid_q <= 1'b0;
            mode_q  <= MODE_CMA;
            mu_q    <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            valid_q <= valid_d;
            mode_q  <= mode_d;
            mu_q    <= mu_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        phase_ok  = (adaptation_phase == PH_CMA) || (adaptation_phase == PH_LMS);
        mode_new  = (adaptation_phase == PH_LMS) ? MODE_LMS : MODE_CMA;
        start     = (state_q == ST_IDLE) && sym_valid && enable && phase_ok;
        handshake = valid_q && upd_ready;
        tap_last  = (tap_q == TAP_W'(NTAPS - 1));
        // Any strobe arriving while a sweep is still owned is lost.
        drop      = (state_q == ST_ISSUE) && sym_valid;

        state_d = state_q;
        tap_d   = tap_q;
        valid_d = valid_q;
        mode_d  = mode_q;
        mu_d    = mu_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q | drop;
        drop_d  = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    tap_d   = '0;
                    valid_d = 1'b1;
                    mode_d  = mode_new;
                    mu_d    = mu_gear;
                end
            end
            ST_ISSUE: begin
                if (handshake) begin
                    if (tap_last) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        tap_d   = tap_q + TAP_W'(1);
                        valid_d = enable;
                    end
                end else if (!valid_q) begin
                    valid_d = enable;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        upd_valid  = valid_q;
        upd_tap    = tap_q;
        upd_mode   = mode_q;
        upd_mu     = mu_q;
        busy       = (state_q == ST_ISSUE);
        sweep_done = done_q;
        overrun    = ovr_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_tap_update_scheduler.sv
// Bench for tap_update_scheduler (NTAPS=5): directed scenarios plus randomized
// sweeps compared against a transaction-level reference model.
module tb_tap_update_scheduler;

    localparam int NT = 5;
    localparam int TW = 5;
    localparam int MW = 16;
    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          sym_valid;
    logic [2:0]    adaptation_phase;
    logic [MW-1:0] mu_cma_init;
    logic [MW-1:0] mu_lms_init;
    logic [31:0]   gear_period;
    logic [GW-1:0] gear_max;
    logic          upd_valid;
    logic          upd_ready;
    logic [TW-1:0] upd_tap;
    logic          upd_mode;
    logic [MW-1:0] upd_mu;
    logic          busy;
    logic          sweep_done;
    logic          overrun;
    logic [15:0]   drop_count;

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_shift, m_cnt, m_last, m_drops;
    bit m_ovr;

    tap_update_scheduler #(.NTAPS(NT), .TAP_W(TW), .MU_W(MW), .GEAR_W(GW)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .sym_valid        (sym_valid),
        .adaptation_phase (adaptation_phase),
        .mu_cma_init      (mu_cma_init),
        .mu_lms_init      (mu_lms_init),
        .gear_period      (gear_period),
        .gear_max         (gear_max),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .upd_tap          (upd_tap),
        .upd_mode         (upd_mode),
        .upd_mu           (upd_mu),
        .busy             (busy),
        .sweep_done       (sweep_done),
        .overrun          (overrun),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_shift = 0;
        m_cnt   = 0;
        m_last  = 0;
        m_drops = 0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_mu(input int mode, output int mu);
        int base;
        base = mode ? int'(mu_lms_init) : int'(mu_cma_init);
        if (mode != m_last) begin
            m_shift = 0;
            m_cnt   = 0;
            m_last  = mode;
        end
        mu = base / (1 << m_shift);
        m_cnt++;
        if (gear_period != 0 && m_cnt == int'(gear_period)) begin
            m_cnt   = 0;
            m_shift = (m_shift + 1 > int'(gear_max)) ? int'(gear_max) : m_shift + 1;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, upd_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, sweep_done, 0);
    endtask

    // One full sweep. Returns cycles from the first command cycle to the
    // sweep_done cycle and the mu seen on the first command.
    task automatic sweep(input int ph, input int stall_pct, input int pause_pct,
                         input int drop_pct, input bit wiggle, input int stall_tap,
                         input int pause_after, input int drop_at,
                         output int cycles, output int first_mu);
        int  mode, mu, acc, cyc, stalled, paused;
        bit  ev, en, rdy, sv;
        mode = (ph == 2) ? 1 : 0;
        model_mu(mode, mu);
        adaptation_phase = 3'(ph);
        enable    = 1'b1;
        upd_ready = 1'b0;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        first_mu  = int'(upd_mu);
        acc = 0; cyc = 0; stalled = 0; paused = 0; ev = 1'b1;
        while (acc < NT && cyc < 200) begin
            chk("sw_valid", upd_valid, ev);
            chk("sw_busy", busy, 1);
            chk("sw_tap", upd_tap, acc);
            chk("sw_mode", upd_mode, mode);
            chk("sw_mu", upd_mu, mu);
            chk("sw_done_low", sweep_done, 0);
            rdy = ($urandom_range(99) >= stall_pct);
            en  = ($urandom_range(99) >= pause_pct);
            sv  = ($urandom_range(99) < drop_pct) || (cyc == drop_at);
            if (acc == stall_tap && stalled < 3) begin
                rdy = 1'b0;
                stalled++;
            end
            if (paused == 1) begin
                en = 1'b0;
                paused = 2;
            end
            if (ev && rdy && acc == pause_after && paused == 0) begin
                en = 1'b0;
                paused = 1;
            end
            if (wiggle) adaptation_phase = 3'($urandom_range(7));
            upd_ready = rdy;
            enable    = en;
            sym_valid = sv;
            if (sv) begin
                m_ovr = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
            if (ev && rdy) begin
                acc++;
                ev = en;
            end else if (!ev) begin
                ev = en;
            end
            tick();
            cyc++;
        end
        sym_valid = 1'b0;
        upd_ready = 1'b0;
        enable    = 1'b1;
        chk("sw_in_budget", (cyc < 200) ? 1 : 0, 1);
        chk("sw_done", sweep_done, 1);
        chk("sw_end_valid", upd_valid, 0);
        chk("sw_end_busy", busy, 0);
        chk("sw_overrun", overrun, m_ovr);
        chk("sw_drops", drop_count, m_drops);
        tick();
        chk("sw_done_pulse", sweep_done, 0);
        cycles = cyc;
    endtask

    initial begin
        int cyc, fmu;
        int gear_exp[6];
        gear_exp = '{32'h1000, 32'h1000, 32'h0800, 32'h0800, 32'h0400, 32'h0400};

        rst = 1'b1;
        enable = 1'b1;
        sym_valid = 1'b0;
        adaptation_phase = 3'd1;
        mu_cma_init = 16'h4000;
        mu_lms_init = 16'h1000;
        gear_period = 32'd0;
        gear_max = 4'd0;
        upd_ready = 1'b0;
        model_reset();
        tick();
        tick();
        chk_idle("rst");
        chk("rst_tap", upd_tap, 0);
        chk("rst_mu", upd_mu, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_drops", drop_count, 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle("idle");
            chk("idle_ovr", overrun, 0);
        end

        // plain sweep, ready always high: NT command cycles then done
        sweep(1, 0, 0, 0, 1'b0, -1, -1, -1, cyc, fmu);
        chk("lat_cycles", cyc, NT);
        chk("lat_mu", fmu, 32'h4000);

        // ready low 3 cycles at tap 2
        sweep(1, 0, 0, 0, 1'b0, 2, -1, -1, cyc, fmu);
        chk("stall_cycles", cyc, NT + 3);

        // enable dropped after tap 1 accepted
        sweep(1, 0, 0, 0, 1'b0, -1, 1, -1, cyc, fmu);
        chk("pause_cycles", cyc, NT + 2);

        // strobe mid-sweep is dropped
        sweep(1, 0, 0, 0, 1'b0, -1, -1, 2, cyc, fmu);
        chk("drop_cycles", cyc, NT);
        chk("drop_ovr", overrun, 1);
        chk("drop_cnt", drop_count, 1);

        // strobes that must be ignored
        for (int k = 0; k < 3; k++) begin
            adaptation_phase = (k == 0) ? 3'd0 : (k == 1) ? 3'd5 : 3'd1;
            enable    = (k == 2) ? 1'b0 : 1'b1;
            sym_valid = 1'b1;
            tick();
            sym_valid = 1'b0;
            enable    = 1'b1;
            chk_idle("ign");
            chk("ign_drops", drop_count, 1);
            tick();
            chk_idle("ign2");
        end

        // gear shifting in LMS
        gear_period = 32'd2;
        gear_max = 4'd2;
        mu_lms_init = 16'h1000;
        for (int i = 0; i < 6; i++) begin
            sweep(2, 0, 0, 0, 1'b0, -1, -1, -1, cyc, fmu);
            chk("gear_mu", fmu, gear_exp[i]);
        end
        sweep(1, 0, 0, 0, 1'b0, -1, -1, -1, cyc, fmu);
        chk("gear_cma_mu", fmu, 32'h4000);

        // reset mid-sweep
        adaptation_phase = 3'd1;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        chk("mrst_pre_valid", upd_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", upd_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ovr", overrun, 0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        chk_idle("mrst_after");

        // randomized sweeps
        gear_period = 32'($urandom_range(3, 1));
        gear_max = 4'($urandom_range(4));
        for (int i = 0; i < 25; i++) begin
            mu_cma_init = 16'($urandom);
            mu_lms_init = 16'($urandom);
            sweep(int'($urandom_range(2, 1)), 30, 15, 10, 1'b1, -1, -1, -1, cyc, fmu);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tap_update_scheduler.md
Name: tap_update_scheduler

Overview:
- Sequences coefficient updates for the adaptive FIR equalizer.
- On each new symbol/error strobe it sweeps tap indices 0..NTAPS-1 to a single shared tap-update engine over a valid/ready handshake.
- Each sweep is tagged with the algorithm (CMA/LMS) taken from the adaptation phase, and a gear-shifted step size.
- Sits between the adaptation phase controller and the tap-update MAC.

Parameters:
- NTAPS, 31, number of equalizer taps (>=2).
- TAP_W, 5, tap index width, >= clog2(NTAPS).
- MU_W, 16, step-size width, unsigned.
- GEAR_W, 4, width of shift count and gear limit.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  gates sweep starts and issue of new taps.
- sym_valid  in  1  one-cycle strobe: new error sample available.
- adaptation_phase  in  3  0 startup, 1 CMA, 2 LMS; other values treated as startup.
- mu_cma_init  in  MU_W  initial CMA step size.
- mu_lms_init  in  MU_W  initial LMS step size.
- gear_period  in  32  sweeps per gear step; 0 disables gear shifting.
- gear_max  in  GEAR_W  maximum right-shift applied to mu.
- upd_valid  out  1  update command valid.
- upd_ready  in  1  tap-update engine accepts command.
- upd_tap  out  TAP_W  tap index of command.
- upd_mode  out  1  0 CMA, 1 LMS.
- upd_mu  out  MU_W  step size for this sweep.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse after last tap accepted.
- overrun  out  1  sticky: a sym_valid was dropped.
- drop_count  out  16  dropped strobes, saturating at 0xFFFF.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; state IDLE; gear shift 0; gear counter 0; last_mode 0.
- States: IDLE, ISSUE.
- IDLE -> ISSUE when sym_valid && enable && phase in {1,2}.
  - Latch mode = (phase==2).
  - If mode != last_mode: shift=0, gear counter=0, then last_mode=mode.
  - upd_mu = (mode ? mu_lms_init : mu_cma_init) >> shift.
  - upd_tap=0, busy=1.
- sym_valid in IDLE with phase 0/other or enable=0: ignored. Not counted as a drop.
- Gear update at sweep start, after mu is computed: counter++; when counter==gear_period: counter=0, shift=min(shift+1, gear_max). gear_period==0: shift stays 0.
- Latency: sym_valid at cycle t -> upd_valid=1 with tap 0 at t+1.
- ISSUE handshake:
  - upd_valid stays high and upd_tap/mode/mu stay stable until upd_ready.
  - On handshake with tap<NTAPS-1: tap++. upd_valid stays high if enable=1. If enable=0, upd_valid drops and tap is held until enable returns.
  - On handshake with tap==NTAPS-1: next cycle state=IDLE, upd_valid=0, busy=0, sweep_done=1 for one cycle.
- With upd_ready held high, a sweep occupies cycles t+1..t+NTAPS; sweep_done is at t+NTAPS+1.
- A new sweep can start on the strobe in the sweep_done cycle.
- sym_valid while in ISSUE, including the last-handshake cycle: dropped. overrun<=1 (sticky until rst); drop_count++ saturating.
- Phase change mid-sweep: the sweep completes with its latched mode/mu. The new mode applies at the next sweep start.
- enable never drops an asserted upd_valid before its handshake.
- Reset mid-sweep: upd_valid and busy go low immediately (asynchronous); the sweep is abandoned.
- upd_tap never exceeds NTAPS-1 and does not wrap.

Decomposition:
- Shared package eq_pkg:
  - phase encodings PH_STARTUP=0, PH_CMA=1, PH_LMS=2.
  - mode encodings MODE_CMA=0, MODE_LMS=1.
  - scheduler state enum.
- One natural sub-module: mu_gear_shifter. It holds the gear counter, shift and last_mode, and produces mu on a sweep-start strobe.

Test Plan:
- Reset then idle, phase=1, no strobes -> all outputs 0 for 20 cycles; assert rst mid-sweep -> upd_valid=0 the same cycle.
- NTAPS=5, phase=1, mu_cma_init=0x4000, upd_ready=1, sym_valid at cycle 10 -> upd_valid cycles 11-15, taps 0..4, mode 0, mu 0x4000; sweep_done at 16.
- Same setup, upd_ready low for 3 cycles while tap=2 -> tap 2, mode and mu held stable; sweep_done at 19.
- sym_valid at cycles 10 and 13 -> single sweep; overrun=1, drop_count=1. Strobe with phase=0 -> no sweep, drop_count unchanged.
- phase=2, mu_lms_init=0x1000, gear_period=2, gear_max=2, 6 sweeps -> mu 0x1000, 0x1000, 0x0800, 0x0800, 0x0400, 0x0400. Switch to phase=1 -> next mu = mu_cma_init unshifted.
- enable=0 after tap 1 accepted -> upd_valid=0, tap held at 2. enable=1 -> resumes at tap 2; the sweep still issues 5 commands in total.
